// File: rtl/temp_sensor_pkg.sv
// Shared types and constants for the serial temperature sensor front-end.
// Optional build macro SENSOR_FAULT_EN is consumed by temp_avg_sat.
package temp_sensor_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        DONE
    } rx_state_t;

    localparam int TEMP_W = 5;
    localparam logic [TEMP_W-1:0] TEMP_SAT_MAX = 5'd31;
    // Mid comfort band: neither heating nor cooling until real data arrives.
    localparam logic [TEMP_W-1:0] TEMP_RESET   = 5'd20;

endpackage

// File: rtl/temp_avg_sat.sv
// Averages 2^AVG_LOG2 sensor readings, saturates to TEMP_W bits, strobes temp_valid.
// Define SENSOR_FAULT_EN to reject all-ones/all-zeros readings and raise fault.
module temp_avg_sat
    import temp_sensor_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int AVG_LOG2  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_valid,
    input  logic [DATA_BITS-1:0] sample,
    output logic [TEMP_W-1:0]    temperature,
    output logic                 temp_valid,
    output logic                 fault
);

    localparam int ACC_W = DATA_BITS + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0]  acc_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [TEMP_W-1:0] temp_reg;
    logic              valid_reg;
    logic [ACC_W-1:0]  sum_next;
    logic [ACC_W-1:0]  avg_next;
    logic [TEMP_W-1:0] sat_next;
    logic              accept;

    always_comb begin
        sum_next = acc_reg + ACC_W'(sample);
        avg_next = sum_next >> AVG_LOG2;
        sat_next = (avg_next > ACC_W'(TEMP_SAT_MAX)) ? TEMP_SAT_MAX : avg_next[TEMP_W-1:0];
    end

`ifdef SENSOR_FAULT_EN
    logic is_fault;
    logic fault_reg;

    // Open line reads all-ones (pull-up), shorted line reads all-zeros.
    assign is_fault = (sample == {DATA_BITS{1'b1}}) || (sample == '0);
    assign accept   = sample_valid && !is_fault;

    always_ff @(posedge clk) begin
        if (rst) begin
            fault_reg <= 1'b0;
        end else if (sample_valid) begin
            fault_reg <= is_fault;
        end
    end

    assign fault = fault_reg;
`else
    assign accept = sample_valid;
    assign fault  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg   <= '0;
            cnt_reg   <= '0;
            temp_reg  <= TEMP_RESET;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            if (accept) begin
                if (cnt_reg == CNT_LAST) begin
                    temp_reg  <= sat_next;
                    valid_reg <= 1'b1;
                    acc_reg   <= '0;
                    cnt_reg   <= '0;
                end else begin
                    acc_reg <= sum_next;
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    end

    assign temperature = temp_reg;
    assign temp_valid  = valid_reg;

endmodule

// File: rtl/temp_sensor_rx.sv
// Periodic SPI-style reader for an 8-bit serial temperature sensor, feeding temp_avg_sat.
// Optional build macro SENSOR_FAULT_EN enables fault detection in the averager.
module temp_sensor_rx
    import temp_sensor_pkg::*;
#(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 1000,
    parameter int DATA_BITS     = 8,
    parameter int AVG_LOG2      = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sdi,
    output logic              sclk,
    output logic              cs_n,
    output logic [TEMP_W-1:0] temperature,
    output logic              temp_valid,
    output logic              fault
);

    localparam int TIMER_W = $clog2(SAMPLE_PERIOD + 1);
    localparam int DIV_W   = $clog2(CLK_DIV + 1);
    localparam int BIT_W   = $clog2(DATA_BITS + 1);

    rx_state_t              state_reg;
    logic [TIMER_W-1:0]     timer_reg;
    logic [DIV_W-1:0]       div_reg;
    logic [BIT_W-1:0]       bit_reg;
    logic [DATA_BITS-1:0]   shift_reg;
    logic                   cs_n_reg;
    logic                   sclk_reg;
    logic                   timer_wrap;
    logic                   div_last;

    assign timer_wrap = (timer_reg == TIMER_W'(SAMPLE_PERIOD - 1));
    assign div_last   = (div_reg == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            timer_reg <= '0;
            div_reg   <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            cs_n_reg  <= 1'b1;
            sclk_reg  <= 1'b0;
        end else begin
            timer_reg <= timer_wrap ? '0 : timer_reg + 1'b1;
            case (state_reg)
                IDLE: begin
                    cs_n_reg <= 1'b1;
                    sclk_reg <= 1'b0;
                    if (timer_wrap) begin
                        state_reg <= SETUP;
                        cs_n_reg  <= 1'b0;
                        div_reg   <= '0;
                        bit_reg   <= '0;
                    end
                end
                SETUP: begin
                    if (div_last) begin
                        div_reg   <= '0;
                        state_reg <= SHIFT;
                    end else begin
                        div_reg <= div_reg + 1'b1;
                    end
                end
                SHIFT: begin
                    if (div_last) begin
                        div_reg  <= '0;
                        sclk_reg <= ~sclk_reg;
                        // Rising edge captures; falling edge counts a completed bit.
                        if (!sclk_reg) begin
                            shift_reg <= {shift_reg[DATA_BITS-2:0], sdi};
                        end else if (bit_reg == BIT_W'(DATA_BITS - 1)) begin
                            bit_reg   <= '0;
                            cs_n_reg  <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            bit_reg <= bit_reg + 1'b1;
                        end
                    end else begin
                        div_reg <= div_reg + 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    temp_avg_sat #(
        .DATA_BITS (DATA_BITS),
        .AVG_LOG2  (AVG_LOG2)
    ) u_avg (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (state_reg == DONE),
        .sample       (shift_reg),
        .temperature  (temperature),
        .temp_valid   (temp_valid),
        .fault        (fault)
    );

    assign cs_n = cs_n_reg;
    assign sclk = sclk_reg;

endmodule
